// File: rtl/hwpe_mem_pkg.sv
// Shared types and defaults for the HWPE slave memory.
// Widths line up with the AXI-to-HWPE bridge.
package hwpe_mem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_state_e;

  localparam int unsigned HWPE_DATA_W      = 32;
  localparam int unsigned HWPE_STRB_W      = HWPE_DATA_W / 8;
  localparam int unsigned HWPE_ROW_W       = 12;
  localparam int unsigned HWPE_N_SLAVE     = 2;
  localparam int unsigned HWPE_READ_LAT    = 1;

  function automatic int unsigned bank_idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hwpe_mem_bank.sv
// Single-port SRAM bank: byte-enable write, registered read.
// Contents are never reset; the read register holds between reads.
module hwpe_mem_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_be,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-masked write or registered read of one row
  always_ff @(posedge clk) begin
    if (i_req) begin
      if (i_we) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/hwpe_s_banked_mem.sv
// HWPE slave memory: N_SLAVE banks, zero-fill init,
// fixed-latency in-order read return.
module hwpe_s_banked_mem
  import hwpe_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH            = HWPE_DATA_W,
  parameter int unsigned STRB_WIDTH            = DATA_WIDTH / 8,
  parameter int unsigned ADDR_MEM_SINGLE_WIDTH = HWPE_ROW_W,
  parameter int unsigned N_SLAVE               = HWPE_N_SLAVE,
  parameter int unsigned ADDR_MEM_TOTAL_WIDTH  =
    ADDR_MEM_SINGLE_WIDTH + $clog2(N_SLAVE),
  parameter int unsigned READ_LATENCY          = HWPE_READ_LAT,
  parameter bit          CLEAR_ON_RESET        = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            HWPE_S_data_req_i,
  input  logic [ADDR_MEM_TOTAL_WIDTH-1:0] HWPE_S_data_add_i,
  input  logic                            HWPE_S_data_wen_i,
  input  logic [DATA_WIDTH-1:0]           HWPE_S_data_wdata_i,
  input  logic [STRB_WIDTH-1:0]           HWPE_S_data_be_i,
  output logic                            HWPE_S_data_gnt_o,
  output logic                            HWPE_S_data_r_valid_o,
  output logic [DATA_WIDTH-1:0]           HWPE_S_data_r_rdata_o,
  output logic                            init_done_o
);

  localparam int unsigned BW  = bank_idx_w(N_SLAVE);
  localparam int unsigned ASW = ADDR_MEM_SINGLE_WIDTH;
  localparam int unsigned L   = READ_LATENCY;

  mem_state_e            r_state;
  logic [ASW-1:0]        r_cnt;
  logic                  r_init_done;
  logic [L-1:0]          r_vld;
  logic [BW-1:0]         r_tag;

  logic                  w_init;
  logic                  w_gnt;
  logic                  w_rd;
  logic [BW-1:0]         w_bank;
  logic [ASW-1:0]        w_row;
  logic [DATA_WIDTH-1:0] w_bank_rdata [N_SLAVE];
  logic [DATA_WIDTH-1:0] w_d0;
  logic [DATA_WIDTH-1:0] w_out;

  assign w_init = rst_n & (r_state == INIT);
  assign w_gnt  = HWPE_S_data_req_i & rst_n
                & (r_state == READY);
  assign w_rd   = w_gnt & ~HWPE_S_data_wen_i;
  assign w_row  = HWPE_S_data_add_i[ASW-1:0];

  if (N_SLAVE > 1) begin : g_multi
    assign w_bank =
      HWPE_S_data_add_i[ADDR_MEM_TOTAL_WIDTH-1:ASW];
    assign w_d0 = w_bank_rdata[r_tag];
  end else begin : g_single
    assign w_bank = '0;
    assign w_d0   = w_bank_rdata[0];
  end

  // Init sweep over all rows, then hold READY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CLEAR_ON_RESET ? INIT : READY;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      unique case (r_state)
        INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state     <= READY;
            r_init_done <= 1'b1;
          end
        end
        READY: r_init_done <= 1'b1;
      endcase
    end
  end

  for (genvar b = 0; b < N_SLAVE; b++) begin : g_bank
    logic                  w_req;
    logic                  w_we;
    logic [ASW-1:0]        w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [STRB_WIDTH-1:0] w_be;

    // Init clear owns the port, else the decoded request
    always_comb begin
      w_req   = w_init
              | (w_gnt & (w_bank == BW'(b)));
      w_we    = w_init | HWPE_S_data_wen_i;
      w_addr  = w_init ? r_cnt : w_row;
      w_wdata = w_init ? '0 : HWPE_S_data_wdata_i;
      w_be    = w_init ? '1 : HWPE_S_data_be_i;
    end

    hwpe_mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH),
      .ADDR_WIDTH (ASW)
    ) u_bank (
      .clk     (clk),
      .i_req   (w_req),
      .i_we    (w_we),
      .i_addr  (w_addr),
      .i_wdata (w_wdata),
      .i_be    (w_be),
      .o_rdata (w_bank_rdata[b])
    );
  end

  // Read valid shift; tag picks the bank one cycle after grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_tag <= '0;
    end else begin
      r_vld[0] <= w_rd;
      for (int i = 1; i < int'(L); i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      if (w_rd) begin
        r_tag <= w_bank;
      end
    end
  end

  if (L > 1) begin : g_dpipe
    logic [DATA_WIDTH-1:0] r_dat [L-1];

    // Carry bank data through the remaining latency stages
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(L) - 1; i++) begin
          r_dat[i] <= '0;
        end
      end else begin
        r_dat[0] <= w_d0;
        for (int i = 1; i < int'(L) - 1; i++) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end

    assign w_out = r_dat[L-2];
  end else begin : g_dnone
    assign w_out = w_d0;
  end

  assign HWPE_S_data_gnt_o     = w_gnt;
  assign HWPE_S_data_r_valid_o = r_vld[L-1];
  assign HWPE_S_data_r_rdata_o =
    r_vld[L-1] ? w_out : '0;
  assign init_done_o           = r_init_done;

endmodule

// File: tb/tb_hwpe_s_banked_mem.sv
// Scoreboard bench for hwpe_s_banked_mem: main DUT
// (2 banks, latency 3, clear) plus a no-clear latency-1 DUT.
module tb_hwpe_s_banked_mem;

  localparam int L  = 3;
  localparam int AW = 13;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic [12:0] add = '0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt, rv, idone;
  logic [31:0] rd;

  logic        rst1_n = 1'b1;
  logic        req1 = 1'b0;
  logic [12:0] add1 = '0;
  logic        wen1 = 1'b0;
  logic [31:0] wdata1 = '0;
  logic [3:0]  be1 = '0;
  logic        gnt1, rv1, idone1;
  logic [31:0] rd1;

  hwpe_s_banked_mem #(
    .DATA_WIDTH(32), .STRB_WIDTH(4),
    .ADDR_MEM_SINGLE_WIDTH(12), .N_SLAVE(2),
    .ADDR_MEM_TOTAL_WIDTH(AW), .READ_LATENCY(L),
    .CLEAR_ON_RESET(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .HWPE_S_data_req_i(req),
    .HWPE_S_data_add_i(add),
    .HWPE_S_data_wen_i(wen),
    .HWPE_S_data_wdata_i(wdata),
    .HWPE_S_data_be_i(be),
    .HWPE_S_data_gnt_o(gnt),
    .HWPE_S_data_r_valid_o(rv),
    .HWPE_S_data_r_rdata_o(rd),
    .init_done_o(idone)
  );

  hwpe_s_banked_mem #(
    .DATA_WIDTH(32), .STRB_WIDTH(4),
    .ADDR_MEM_SINGLE_WIDTH(12), .N_SLAVE(2),
    .ADDR_MEM_TOTAL_WIDTH(AW), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1'b0)
  ) u_dut1 (
    .clk(clk), .rst_n(rst1_n),
    .HWPE_S_data_req_i(req1),
    .HWPE_S_data_add_i(add1),
    .HWPE_S_data_wen_i(wen1),
    .HWPE_S_data_wdata_i(wdata1),
    .HWPE_S_data_be_i(be1),
    .HWPE_S_data_gnt_o(gnt1),
    .HWPE_S_data_r_valid_o(rv1),
    .HWPE_S_data_r_rdata_o(rd1),
    .init_done_o(idone1)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] model [8192];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old,
      logic [31:0] d, logic [3:0] b);
    logic [31:0] o;
    o = old;
    for (int i = 0; i < 4; i++)
      if (b[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  // Response monitor: pops and compares on every r_valid
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_missing: due %0d now %0d",
               q[0].due, cyc);
      void'(q.pop_front());
    end
    if (rv === 1'b1) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'(rv), 32'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
        chk("rsp_data", rd, e.data);
      end
    end else begin
      chk("rdata_idle", rd, 32'd0);
      chk("rvalid_known", 32'(rv), 32'd0);
    end
  end

  task automatic issue(bit w, int a, logic [31:0] d,
                       logic [3:0] b);
    int waitc = 0;
    @(negedge clk);
    req = 1'b1; wen = w; add = a[12:0];
    wdata = d; be = b;
    #1;
    while (gnt !== 1'b1) begin
      waitc++;
      if (waitc > 5000) begin
        chk("gnt_timeout", 32'(gnt), 32'd1);
        req = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    if (w) model[a] = merge(model[a], d, b);
    else q.push_back('{due: cyc + L, data: model[a]});
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0;
  endtask

  // Called right after rst_n rises at a negedge, req held
  task automatic init_phase();
    int bad_g = 0;
    int bad_d = 0;
    for (int k = 1; k <= 4096; k++) begin
      @(negedge clk);
      #1;
      if (k < 4096) begin
        if (gnt !== 1'b0) bad_g++;
        if (idone !== 1'b0) bad_d++;
      end else begin
        chk("init_gnt_low", 32'(bad_g), 32'd0);
        chk("init_done_low", 32'(bad_d), 32'd0);
        chk("init_done_rise", 32'(idone), 32'd1);
        chk("init_first_gnt", 32'(gnt), 32'd1);
        for (int i = 0; i < 8192; i++) model[i] = '0;
        if (gnt === 1'b1 && !wen)
          q.push_back('{due: cyc + L,
                        data: model[int'(add)]});
      end
    end
  endtask

  int pool [10] = '{0, 1, 5, 'h10, 'h7FF, 'hFFF,
                    'h1000, 'h1001, 'h1005, 'h1FFF};

  initial begin
    int a;
    #1;
    rst_n = 1'b0;
    rst1_n = 1'b0;
    req = 1'b1; add = '0; wen = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rv), 32'd0);
    chk("rst_rdata", rd, 32'd0);
    chk("rst_init_done", 32'(idone), 32'd0);

    req1 = 1'b1; wen1 = 1'b1; add1 = 13'h1ABC;
    wdata1 = 32'h12345678; be1 = 4'hF;
    #1;
    chk("d1_rst_gnt", 32'(gnt1), 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;
    #1;
    chk("d1_gnt_first", 32'(gnt1), 32'd1);
    chk("d1_done_low", 32'(idone1), 32'd0);
    @(negedge clk);
    chk("d1_done_high", 32'(idone1), 32'd1);
    chk("d1_no_rv_wr", 32'(rv1), 32'd0);
    wen1 = 1'b0;
    #1;
    chk("d1_gnt_rd", 32'(gnt1), 32'd1);
    @(negedge clk);
    chk("d1_rv", 32'(rv1), 32'd1);
    chk("d1_rdata", rd1, 32'h12345678);
    req1 = 1'b0;
    @(negedge clk);
    chk("d1_rv_once", 32'(rv1), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    init_phase();

    issue(1, 'h0005, 32'hDEADBEEF, 4'hF);
    issue(1, 'h1005, 32'hCAFEF00D, 4'hF);
    issue(0, 'h0005, '0, '0);
    issue(0, 'h1005, '0, '0);
    issue(1, 'h0010, 32'h11223344, 4'hF);
    issue(1, 'h0010, 32'hAABBCCDD, 4'b0101);
    issue(0, 'h0010, '0, '0);
    issue(1, 'h0FFF, 32'h0F0F0F0F, 4'hF);
    issue(1, 'h1000, 32'h10001000, 4'hF);
    idle();
    issue(0, 'h0FFF, '0, '0);
    issue(0, 'h1000, '0, '0);
    issue(0, 'h0FFF, '0, '0);
    issue(1, 'h1FFF, 32'h5A5A1234, 4'hF);
    issue(0, 'h1FFF, '0, '0);

    repeat (1500) begin
      if ($urandom_range(0, 9) == 0) begin
        idle();
      end else begin
        if ($urandom_range(0, 3) == 0)
          a = int'($urandom_range(0, 8191));
        else
          a = pool[$urandom_range(0, 9)];
        issue(1'($urandom_range(0, 1)), a, $urandom,
              4'($urandom_range(0, 15)));
      end
    end
    idle();
    repeat (L + 2) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);

    issue(0, 'h0005, '0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    req = 1'b1; wen = 1'b0; add = 13'h0005;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_done", 32'(idone), 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reinit_gnt", 32'(gnt), 32'd0);
    init_phase();
    issue(0, 'h1005, '0, '0);
    issue(0, 'h1FFF, '0, '0);
    idle();
    repeat (L + 2) @(negedge clk);
    chk("drain_end", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
